// File: rtl/taquito_arbiter.sv
// Round-robin arbiter sharing one taquito flavour decoder between four order stations.
// Optional served-order counter enabled by defining TAQUITO_ARB_STATS_EN.
module taquito_arbiter #(
  parameter int COOK_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [7:0]  b_in,
  output logic [3:0]  sabor,
  output logic [3:0]  grant,
  output logic        busy,
  output logic [7:0]  plato,
  output logic        plato_valid,
  output logic [1:0]  plato_id
`ifdef TAQUITO_ARB_STATS_EN
  ,
  output logic [15:0] served_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, COOK, SERVE} state_t;

  state_t           state_reg, state_next;
  logic [3:0]       grant_reg, grant_next;
  logic [1:0]       win_reg, win_next;
  logic [1:0]       ptr_reg, ptr_next;
  logic [1:0]       id_reg, id_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       plato_reg, plato_next;

  logic             pick_found;
  logic [1:0]       pick_idx;
  logic [1:0]       cand;

  // Scan from the station after the last one served, wrapping mod 4.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = ptr_reg;
    cand       = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_reg + 2'(k);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    win_next   = win_reg;
    ptr_next   = ptr_reg;
    id_next    = id_reg;
    cnt_next   = cnt_reg;
    plato_next = plato_reg;
    case (state_reg)
      IDLE: begin
        if (pick_found) begin
          grant_next = 4'b0001 << pick_idx;
          win_next   = pick_idx;
          cnt_next   = CNT_W'(COOK_CYCLES - 1);
          state_next = COOK;
        end
      end
      COOK: begin
        // A dropped request abandons the order and wins over expiry.
        if (!req[win_reg]) begin
          grant_next = '0;
          state_next = IDLE;
        end else if (cnt_reg == '0) begin
          plato_next = b_in;
          id_next    = win_reg;
          state_next = SERVE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      SERVE: begin
        ptr_next   = win_reg;
        grant_next = '0;
        state_next = IDLE;
      end
      default: begin
        grant_next = '0;
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      win_reg   <= '0;
      ptr_reg   <= 2'd3;
      id_reg    <= '0;
      cnt_reg   <= '0;
      plato_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      win_reg   <= win_next;
      ptr_reg   <= ptr_next;
      id_reg    <= id_next;
      cnt_reg   <= cnt_next;
      plato_reg <= plato_next;
    end
  end

  assign sabor       = (state_reg == COOK) ? grant_reg : 4'b0000;
  assign grant       = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign plato       = plato_reg;
  assign plato_valid = (state_reg == SERVE);
  assign plato_id    = id_reg;

`ifdef TAQUITO_ARB_STATS_EN
  logic [15:0] served_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      served_reg <= '0;
    end else if (state_reg == SERVE) begin
      served_reg <= served_reg + 16'd1;
    end
  end

  assign served_cnt = served_reg;
`endif

endmodule
